// File: rtl/sram_row_sched.sv
// sram_row_sched
//   Burst-level scheduler for the single row/k port of the M x KMAX
//   attention-score SRAM. A writer and a reader each post burst commands
//   (row, start k, length). Commands are granted round-robin from IDLE only.
//   The scheduler issues one SRAM access per cycle and drains all outstanding
//   reads before the next grant, so read and write bursts never overlap.
//
//   Optional feature, macro SRAM_SCHED_BOUNDS_CHK_EN:
//     defined   - a command with row >= M or k+len > KMAX is accepted but
//                 rejected: no SRAM access, err and the matching done pulse
//                 fire together the next cycle.
//     undefined - no check, err tied low, k wraps KMAX-1 -> 0 in the row.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   wr_req_* / wr_req_ready       write burst command handshake
//   wr_dvalid/wr_dready/wr_wdata/wr_wmask  write beat stream
//   wr_done                       pulse, write burst complete
//   rd_req_* / rd_req_ready       read burst command handshake
//   rd_dvalid/rd_rdata/rd_last    read data return (no backpressure)
//   rd_done                       pulse, all read data returned
//   busy, err                     state != IDLE, rejected-command pulse
//   m_*                           SRAM port (controls, address, data)
module sram_row_sched #(
  parameter int M      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int ROW_W  = (M > 1) ? $clog2(M) : 1,
  parameter int K_W    = (KMAX > 1) ? $clog2(KMAX) : 1,
  parameter int LEN_W  = K_W + 1,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ROW_W-1:0]  wr_req_row,
  input  logic [K_W-1:0]    wr_req_k,
  input  logic [LEN_W-1:0]  wr_req_len,
  input  logic              wr_dvalid,
  output logic              wr_dready,
  input  logic [DATA_W-1:0] wr_wdata,
  input  logic [BYTE_W-1:0] wr_wmask,
  output logic              wr_done,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ROW_W-1:0]  rd_req_row,
  input  logic [K_W-1:0]    rd_req_k,
  input  logic [LEN_W-1:0]  rd_req_len,
  output logic              rd_dvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              rd_last,
  output logic              rd_done,
  output logic              busy,
  output logic              err,
  output logic              m_en,
  output logic              m_re,
  output logic              m_we,
  output logic [ROW_W-1:0]  m_row,
  output logic [K_W-1:0]    m_k,
  output logic [DATA_W-1:0] m_wdata,
  output logic [BYTE_W-1:0] m_wmask,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

  state_t           state_reg;
  logic [ROW_W-1:0] cur_row_reg;
  logic [K_W-1:0]   cur_k_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [OUT_W-1:0] out_reg;
  logic             rr_rd_last_reg;  // 1: reader was granted most recently
  logic             wr_done_reg;
  logic             rd_done_reg;
  logic             err_reg;

  logic             idle;
  logic             grant_wr;
  logic             grant_rd;
  logic [ROW_W-1:0] sel_row;
  logic [K_W-1:0]   sel_k;
  logic [LEN_W-1:0] sel_len;
  logic             bad_cmd;
  logic             wr_beat;
  logic             rd_issue;
  logic             rd_ret;
  logic [K_W-1:0]   k_inc;
  logic [OUT_W-1:0] out_next;

  // Round-robin: on a tie the requester not granted last wins.
  assign idle     = (state_reg == S_IDLE);
  assign grant_wr = idle && wr_req_valid && (!rd_req_valid || rr_rd_last_reg);
  assign grant_rd = idle && rd_req_valid && (!wr_req_valid || !rr_rd_last_reg);

  assign sel_row = grant_wr ? wr_req_row : rd_req_row;
  assign sel_k   = grant_wr ? wr_req_k   : rd_req_k;
  assign sel_len = grant_wr ? wr_req_len : rd_req_len;

`ifdef SRAM_SCHED_BOUNDS_CHK_EN
  assign bad_cmd = (32'(sel_row) >= 32'(M)) ||
                   ((32'(sel_k) + 32'(sel_len)) > 32'(KMAX));
`else
  assign bad_cmd = 1'b0;
`endif

  assign wr_beat  = (state_reg == S_WR) && wr_dvalid;
  assign rd_issue = (state_reg == S_RD);
  // Returns with nothing outstanding (e.g. left over from a reset mid-burst)
  // are dropped here and never reach the reader.
  assign rd_ret   = m_rvalid && (out_reg != '0);

  assign k_inc    = (cur_k_reg == K_W'(KMAX - 1)) ? '0 : cur_k_reg + 1'b1;
  assign out_next = out_reg + {{(OUT_W-1){1'b0}}, rd_issue}
                            - {{(OUT_W-1){1'b0}}, rd_ret};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      cur_row_reg    <= '0;
      cur_k_reg      <= '0;
      cnt_reg        <= '0;
      out_reg        <= '0;
      rr_rd_last_reg <= 1'b1;
      wr_done_reg    <= 1'b0;
      rd_done_reg    <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      wr_done_reg <= 1'b0;
      rd_done_reg <= 1'b0;
      err_reg     <= 1'b0;
      out_reg     <= out_next;
      case (state_reg)
        S_IDLE: begin
          if (grant_wr || grant_rd) begin
            rr_rd_last_reg <= grant_rd;
            cur_row_reg    <= sel_row;
            cur_k_reg      <= sel_k;
            cnt_reg        <= sel_len;
            if (bad_cmd) begin
              err_reg     <= 1'b1;
              wr_done_reg <= grant_wr;
              rd_done_reg <= grant_rd;
            end else if (sel_len == '0) begin
              // Empty burst: completes without touching the SRAM.
              wr_done_reg <= grant_wr;
              rd_done_reg <= grant_rd;
            end else begin
              state_reg <= grant_wr ? S_WR : S_RD;
            end
          end
        end
        S_WR: begin
          if (wr_dvalid) begin
            cur_k_reg <= k_inc;
            cnt_reg   <= cnt_reg - 1'b1;
            if (cnt_reg == LEN_W'(1)) begin
              state_reg   <= S_IDLE;
              wr_done_reg <= 1'b1;
            end
          end
        end
        S_RD: begin
          cur_k_reg <= k_inc;
          cnt_reg   <= cnt_reg - 1'b1;
          if (cnt_reg == LEN_W'(1)) begin
            state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_next == '0) begin
            state_reg   <= S_IDLE;
            rd_done_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // The command handshake is decoded from inputs, so it is also forced low
  // while reset is held.
  assign wr_req_ready = grant_wr && rst;
  assign rd_req_ready = grant_rd && rst;
  assign wr_dready    = (state_reg == S_WR);
  assign wr_done      = wr_done_reg;
  assign rd_done      = rd_done_reg;
  assign err          = err_reg;
  assign busy         = !idle;

  assign rd_dvalid = rd_ret;
  assign rd_rdata  = rd_ret ? m_rdata : '0;
  // Final beat: every read has been issued and this is the last one in flight.
  assign rd_last   = rd_ret && (cnt_reg == '0) && (out_reg == OUT_W'(1)) && !rd_issue;

  assign m_en    = wr_beat || rd_issue;
  assign m_we    = wr_beat;
  assign m_re    = rd_issue;
  assign m_row   = m_en ? cur_row_reg : '0;
  assign m_k     = m_en ? cur_k_reg : '0;
  assign m_wdata = wr_beat ? wr_wdata : '0;
  assign m_wmask = wr_beat ? wr_wmask : '0;

endmodule

// File: tb/tb_sram_row_sched.sv
// Testbench for sram_row_sched: table of burst commands plus hand-written
// sequences for arbitration, reset mid-burst and the bounds-check option.
// A behavioural SRAM with read latency 1 sits on the m_* port.
module tb_sram_row_sched;

  localparam int M      = 6;
  localparam int KMAX   = 1024;
  localparam int DATA_W = 32;
  localparam int BYTE_W = DATA_W / 8;
  localparam int ROW_W  = $clog2(M);
  localparam int K_W    = $clog2(KMAX);
  localparam int LEN_W  = K_W + 1;

  logic              clk;
  logic              rst;
  logic              wr_req_valid, wr_req_ready;
  logic [ROW_W-1:0]  wr_req_row;
  logic [K_W-1:0]    wr_req_k;
  logic [LEN_W-1:0]  wr_req_len;
  logic              wr_dvalid, wr_dready;
  logic [DATA_W-1:0] wr_wdata;
  logic [BYTE_W-1:0] wr_wmask;
  logic              wr_done;
  logic              rd_req_valid, rd_req_ready;
  logic [ROW_W-1:0]  rd_req_row;
  logic [K_W-1:0]    rd_req_k;
  logic [LEN_W-1:0]  rd_req_len;
  logic              rd_dvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic              rd_last, rd_done, busy, err;
  logic              m_en, m_re, m_we;
  logic [ROW_W-1:0]  m_row;
  logic [K_W-1:0]    m_k;
  logic [DATA_W-1:0] m_wdata;
  logic [BYTE_W-1:0] m_wmask;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid;

  sram_row_sched #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_row(wr_req_row), .wr_req_k(wr_req_k), .wr_req_len(wr_req_len),
    .wr_dvalid(wr_dvalid), .wr_dready(wr_dready),
    .wr_wdata(wr_wdata), .wr_wmask(wr_wmask), .wr_done(wr_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_row(rd_req_row), .rd_req_k(rd_req_k), .rd_req_len(rd_req_len),
    .rd_dvalid(rd_dvalid), .rd_rdata(rd_rdata), .rd_last(rd_last),
    .rd_done(rd_done), .busy(busy), .err(err),
    .m_en(m_en), .m_re(m_re), .m_we(m_we), .m_row(m_row), .m_k(m_k),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rdata(m_rdata), .m_rvalid(m_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural SRAM, read latency 1 ----------------
  logic [DATA_W-1:0] mem [0:M*KMAX-1];
  logic              model_v, pend_v, stray;
  logic [DATA_W-1:0] model_d, pend_d;
  assign m_rvalid = model_v | stray;
  assign m_rdata  = model_d;

  initial begin
    model_v = 1'b0; pend_v = 1'b0; stray = 1'b0;
    model_d = '0;   pend_d = '0;
    for (int i = 0; i < M*KMAX; i++) mem[i] = 32'h5EED_0000 | i;
  end

  // Present last cycle's read at the falling edge; sample this cycle's
  // access just before the rising edge.
  always begin
    @(negedge clk);
    model_v = pend_v;
    model_d = pend_d;
    #4;
    pend_v = m_en && m_re;
    if (m_en && m_re) pend_d = mem[int'(m_row)*KMAX + int'(m_k)];
    if (m_en && m_we)
      for (int b = 0; b < BYTE_W; b++)
        if (m_wmask[b]) mem[int'(m_row)*KMAX + int'(m_k)][8*b +: 8] = m_wdata[8*b +: 8];
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    bit          is_wr;
    int          row;
    int          k;
    int          len;
    logic [31:0] base;    // beat i carries base+i
    int          gap;     // write beat index preceded by one idle cycle, -1 none
    int          last_k;  // hand-computed k of the final beat
  } vec_t;

  function automatic vec_t mkv(input bit is_wr, input int row, input int k, input int len,
                               input logic [31:0] base, input int gap, input int last_k);
    vec_t v;
    v.is_wr = is_wr; v.row = row; v.k = k; v.len = len;
    v.base = base; v.gap = gap; v.last_k = last_k;
    return v;
  endfunction

  // Called on the falling edge right after a write grant.
  task automatic collect_write(input int row, input int k, input int len,
                               input logic [31:0] base, input int gap, input int last_k);
    int i = 0;
    int cyc = 0;
    int seen_k = -1;
    bit gapped = 1'b0;
    while (i < len && cyc < 64) begin
      if (i == gap && !gapped) begin
        wr_dvalid = 1'b0;
        gapped = 1'b1;
        #1;
        chk("wr_gap_m_en", m_en, 0);
        chk("wr_gap_dready", wr_dready, 1);
      end else begin
        wr_dvalid = 1'b1;
        wr_wdata  = base + i;
        wr_wmask  = '1;
        #1;
        chk("wr_m_en_we_re", {m_en, m_we, m_re}, 3'b110);
        chk("wr_m_row", m_row, row);
        chk("wr_m_k", m_k, (k + i) % KMAX);
        chk("wr_m_wdata", m_wdata, base + i);
        chk("wr_m_wmask", m_wmask, 4'hF);
        seen_k = int'(m_k);
        i++;
      end
      chk("wr_done_early", wr_done, 0);
      chk("wr_rd_ready_held", rd_req_ready, 0);
      chk("wr_err", err, 0);
      @(negedge clk);
      cyc++;
    end
    wr_dvalid = 1'b0;
    #1;
    n_tests++;
    if (i != len) begin
      n_fail++;
      $display("FAIL wr_timeout: got %0d beats, required %0d", i, len);
    end
    chk("wr_done", wr_done, 1);
    chk("wr_busy_after", busy, 0);
    chk("wr_m_en_after", m_en, 0);
    if (len > 0) chk("wr_last_k", seen_k, last_k);
    $display("[TB] write row=%0d k=%0d len=%0d beats=%0d done", row, k, len, i);
  endtask

  // Called on the falling edge right after a read grant.
  task automatic collect_read(input int row, input int k, input int len,
                              input logic [31:0] base, input int last_k);
    int issues = 0;
    int rets = 0;
    int last_ret = -1;
    int cyc = 0;
    int seen_k = -1;
    bit done = 1'b0;
    while (!done && cyc < 64) begin
      #1;
      chk("rd_m_re", m_re, (cyc < len));
      chk("rd_err", err, 0);
      if (m_re) begin
        chk("rd_m_en_we", {m_en, m_we}, 2'b10);
        chk("rd_m_row", m_row, row);
        chk("rd_m_k", m_k, (k + issues) % KMAX);
        seen_k = int'(m_k);
        issues++;
      end
      if (rd_dvalid) begin
        chk("rd_data", rd_rdata, base + rets);
        chk("rd_last", rd_last, (rets == len - 1));
        last_ret = cyc;
        rets++;
      end else begin
        chk("rd_last_idle", rd_last, 0);
      end
      if (rd_done) begin
        chk("rd_done_cycle", cyc, last_ret + 1);
        chk("rd_returns", rets, len);
        chk("rd_issues", issues, len);
        chk("rd_busy_after", busy, 0);
        done = 1'b1;
      end else begin
        chk("rd_wr_ready_held", wr_req_ready, 0);
        @(negedge clk);
        cyc++;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL rd_timeout: got no rd_done, required one within 64 cycles");
    end
    if (len > 0) chk("rd_last_k", seen_k, last_k);
    $display("[TB] read  row=%0d k=%0d len=%0d returns=%0d done", row, k, len, rets);
  endtask

  task automatic run_write(input vec_t v);
    @(negedge clk);
    wr_req_valid = 1'b1;
    wr_req_row   = ROW_W'(v.row);
    wr_req_k     = K_W'(v.k);
    wr_req_len   = LEN_W'(v.len);
    #1;
    chk("wr_req_ready", wr_req_ready, 1);
    @(negedge clk);
    wr_req_valid = 1'b0;
    collect_write(v.row, v.k, v.len, v.base, v.gap, v.last_k);
  endtask

  task automatic run_read(input vec_t v);
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_row   = ROW_W'(v.row);
    rd_req_k     = K_W'(v.k);
    rd_req_len   = LEN_W'(v.len);
    #1;
    chk("rd_req_ready", rd_req_ready, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    collect_read(v.row, v.k, v.len, v.base, v.last_k);
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mkv(1'b1, 2,    5, 4, 32'hA0,  2,   8));
    vecs.push_back(mkv(1'b0, 2,    5, 4, 32'hA0, -1,   8));
`ifndef SRAM_SCHED_BOUNDS_CHK_EN
    vecs.push_back(mkv(1'b1, 0, 1022, 4, 32'hB0, -1,   1));
    vecs.push_back(mkv(1'b0, 0, 1022, 4, 32'hB0, -1,   1));
`endif
    vecs.push_back(mkv(1'b1, 5,    0, 1, 32'hC0, -1,   0));
    vecs.push_back(mkv(1'b0, 5,    0, 1, 32'hC0, -1,   0));
    vecs.push_back(mkv(1'b1, 1,   10, 0, 32'hC8, -1,  -1));
    vecs.push_back(mkv(1'b0, 1,   10, 0, 32'hC8, -1,  -1));
    vecs.push_back(mkv(1'b1, 3,  100, 3, 32'h55AA0000, 0, 102));
    vecs.push_back(mkv(1'b0, 3,  100, 3, 32'h55AA0000, -1, 102));

    rst = 1'b0;
    wr_req_valid = 1'b1;  // held during reset: handshake must stay low
    wr_req_row = '0; wr_req_k = '0; wr_req_len = LEN_W'(1);
    wr_dvalid = 1'b0; wr_wdata = '0; wr_wmask = '0;
    rd_req_valid = 1'b0; rd_req_row = '0; rd_req_k = '0; rd_req_len = '0;

    // ---- reset state ----
    @(negedge clk);
    #1;
    chk("reset_ctrl_outs",
        {wr_req_ready, rd_req_ready, wr_dready, wr_done, rd_dvalid, rd_last,
         rd_done, busy, err, m_en, m_re, m_we}, 12'h000);
    chk("reset_m_addr", {m_row, m_k}, 0);
    chk("reset_m_data", {m_wdata, m_wmask}, 0);
    chk("reset_rd_rdata", rd_rdata, 0);
    wr_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // ---- simultaneous requests from reset: WR wins, then RD wins ----
    @(negedge clk);
    wr_req_valid = 1'b1; wr_req_row = 3'd4; wr_req_k = '0; wr_req_len = LEN_W'(2);
    rd_req_valid = 1'b1; rd_req_row = 3'd4; rd_req_k = '0; rd_req_len = LEN_W'(2);
    #1;
    chk("arb1_wr_ready", wr_req_ready, 1);
    chk("arb1_rd_ready", rd_req_ready, 0);
    @(negedge clk);
    wr_req_valid = 1'b0;
    collect_write(4, 0, 2, 32'hD0, -1, 1);
    // Writer posts its next burst while the reader is still waiting.
    wr_req_valid = 1'b1; wr_req_k = K_W'(2);
    #1;
    chk("arb2_rd_ready", rd_req_ready, 1);
    chk("arb2_wr_ready", wr_req_ready, 0);
    @(negedge clk);
    rd_req_valid = 1'b0;
    collect_read(4, 0, 2, 32'hD0, 1);
    #1;
    chk("arb3_wr_ready", wr_req_ready, 1);
    @(negedge clk);
    wr_req_valid = 1'b0;
    collect_write(4, 2, 2, 32'hE0, -1, 3);

    // ---- table of bursts ----
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) run_write(vecs[i]);
      else               run_read(vecs[i]);
    end

    // ---- reset during a read burst after 3 of 8 issues ----
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_row = 3'd3; rd_req_k = '0; rd_req_len = LEN_W'(8);
    #1;
    chk("rst_rd_ready", rd_req_ready, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_rd_issue", m_re, 1);
      @(negedge clk);
    end
    rst = 1'b0;  // a return for issue 3 is on m_rvalid right now
    #1;
    chk("rst_mid_outs",
        {wr_req_ready, rd_req_ready, wr_dready, wr_done, rd_dvalid, rd_last,
         rd_done, busy, err, m_en, m_re, m_we}, 12'h000);
    chk("rst_mid_rdata", rd_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    stray = 1'b1;
    #1;
    chk("stray_dvalid", rd_dvalid, 0);
    chk("stray_rdata", rd_rdata, 0);
    @(negedge clk);
    stray = 1'b0;
    #1;
    chk("stray_no_done", {rd_done, rd_dvalid, busy}, 3'b000);
    $display("[TB] reset  mid-read after 3 issues, stray return dropped");
    run_write(mkv(1'b1, 1, 20, 2, 32'hF0, -1, 21));
    run_read(mkv(1'b0, 1, 20, 2, 32'hF0, -1, 21));

`ifdef SRAM_SCHED_BOUNDS_CHK_EN
    // ---- rejected commands ----
    @(negedge clk);
    wr_req_valid = 1'b1; wr_req_row = ROW_W'(M); wr_req_k = '0; wr_req_len = LEN_W'(1);
    #1;
    chk("bad_wr_ready", wr_req_ready, 1);
    @(negedge clk);
    wr_req_valid = 1'b0;
    #1;
    chk("bad_wr_err_done", {err, wr_done}, 2'b11);
    chk("bad_wr_quiet", {m_en, wr_dready, busy}, 3'b000);
    @(negedge clk);
    #1;
    chk("bad_wr_err_pulse", err, 0);
    $display("[TB] write row=%0d rejected", M);
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_row = '0; rd_req_k = K_W'(KMAX - 2); rd_req_len = LEN_W'(4);
    #1;
    chk("bad_rd_ready", rd_req_ready, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    #1;
    chk("bad_rd_err_done", {err, rd_done}, 2'b11);
    chk("bad_rd_quiet", {m_en, busy}, 2'b00);
    $display("[TB] read  k=%0d len=4 rejected", KMAX - 2);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_row_sched.md
Name: sram_row_sched

Overview:
- Burst-level scheduler sharing the single row/k access port of the M x KMAX attention-score SRAM between a writer (score/operand loader) and a reader (row streamer).
- Each requester issues a burst command (row, start k, length).
- The scheduler grants bursts round-robin and sequences one SRAM access per cycle.
- It tracks outstanding reads and drains them before the next grant, so read and write bursts never overlap.

Parameters:
- M, 8, number of rows
- KMAX, 1024, words per row
- DATA_W, 32, word width
- BYTE_W, DATA_W/8, write-mask width
- ROW_W, clog2(M) (min 1), row index width
- K_W, clog2(KMAX) (min 1), k index width
- LEN_W, K_W+1, burst length width (beats)
- OUT_W, 4, outstanding-read counter width; must hold SRAM read latency + 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- wr_req_valid  in  1  write burst request
- wr_req_ready  out  1  write burst accepted this cycle
- wr_req_row  in  ROW_W  target row
- wr_req_k  in  K_W  start k
- wr_req_len  in  LEN_W  beats
- wr_dvalid  in  1  write beat valid
- wr_dready  out  1  write beat consumed
- wr_wdata  in  DATA_W  beat data
- wr_wmask  in  BYTE_W  beat byte mask
- wr_done  out  1  one-cycle pulse, write burst complete
- rd_req_valid  in  1  read burst request
- rd_req_ready  out  1  read burst accepted
- rd_req_row  in  ROW_W  row
- rd_req_k  in  K_W  start k
- rd_req_len  in  LEN_W  beats
- rd_dvalid  out  1  read data valid (no backpressure)
- rd_rdata  out  DATA_W  read data
- rd_last  out  1  final beat of burst
- rd_done  out  1  one-cycle pulse, all read data returned
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse, rejected command (0 without macro)
- m_en, m_re, m_we  out  1 each  SRAM port controls
- m_row  out  ROW_W  SRAM row
- m_k  out  K_W  SRAM k
- m_wdata  out  DATA_W  SRAM write data
- m_wmask  out  BYTE_W  SRAM write mask
- m_rdata  in  DATA_W  SRAM read data
- m_rvalid  in  1  SRAM read data valid

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all counters 0; rr pointer=RD, so WR wins the first tie.
  - All outputs 0.
- States: IDLE, WR, RD, DRAIN.
- IDLE arbitration:
  - One valid requester: grant it.
  - Both valid: grant the one not granted last.
  - req_ready of the granted requester is asserted combinationally for that IDLE cycle only.
  - Latch row, k, len into cur_row, cur_k, cnt; update rr pointer.
  - len==0: accept, no SRAM access, corresponding done pulses next cycle, stay IDLE.
- WR:
  - wr_dready=1.
  - Per cycle with wr_dvalid=1: m_en=m_we=1, m_re=0, m_row/m_k=cur_row/cur_k, m_wdata/m_wmask=wr_wdata/wr_wmask (combinational). Then cur_k++, cnt--.
  - wr_dvalid=0 holds state with no access.
  - After the beat that makes cnt=0: go to IDLE; wr_done pulses the next cycle.
- RD:
  - Every cycle: m_en=m_re=1, m_we=0, address cur_row/cur_k; cur_k++, cnt--, outstanding++.
  - After the last issue: go to DRAIN.
- Outstanding counter:
  - m_rvalid with outstanding>0 decrements it.
  - Simultaneous issue and return leave it unchanged.
- Read return:
  - rd_dvalid = m_rvalid && outstanding!=0; rd_rdata = m_rdata.
  - rd_last = rd_dvalid && cnt==0 && outstanding==1, with no issue in the same cycle.
- DRAIN: when outstanding reaches 0, go to IDLE; rd_done pulses the next cycle.
- The next grant only happens from IDLE, so write-after-read and read-after-write bursts are strictly ordered.
- k wrap (no macro): cur_k at KMAX-1 wraps to 0 in the same row.
- Stray returns: m_rvalid with outstanding==0 (e.g. after reset mid-burst) is dropped, not forwarded.
- Reset mid-burst: remaining beats are abandoned; no done pulse is issued.

Optional Feature:
- Macro: SRAM_SCHED_BOUNDS_CHK_EN.
- Defined: on grant, if row>=M or k+len>KMAX, the command is accepted (ready pulses) but rejected.
  - No SRAM access.
  - err and the matching done pulse together the next cycle; state stays IDLE.
  - wr_dready stays 0, so the writer must not send data for a rejected burst.
- Undefined: no check; err tied 0; k wraps as above.

Test Plan:
- Write row 2, k=5, len=4, data 0xA0..0xA3, wr_dvalid gapped on beat 2 -> m_we pulses exactly 4 times at k=5,6,7,8; wr_done one cycle after the last beat.
- Read row 2, k=5, len=4, SRAM latency 1 -> m_re asserted 4 consecutive cycles; rd_dvalid returns 0xA0..0xA3; rd_last on 0xA3; rd_done the next cycle; busy low after.
- wr_req_valid and rd_req_valid asserted together from reset, len=2 each -> WR granted first, RD granted only after wr_done; second simultaneous pair -> RD granted first.
- Read row 0, k=KMAX-2, len=4 (no macro) -> m_k sequence KMAX-2, KMAX-1, 0, 1 on row 0.
- rst=0 during RD after 3 of 8 issues, then rst=1 -> outputs 0 immediately; late m_rvalid not forwarded; new write command granted normally.
- With SRAM_SCHED_BOUNDS_CHK_EN, write row M, len=1 -> wr_req_ready pulses; no m_en; err and wr_done pulse together the next cycle.
